// File: rtl/ooo6502_mem_pkg.sv
// Shared memory-bus widths and element types for the out-of-order 6502 core.
package ooo6502_mem_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the port arbiter, flattened per requester/port.
interface mem_port_arbiter_if #(
   parameter int NREQ  = 3,
   parameter int NPORT = 2,
   parameter int TAGW  = 4
);
   import ooo6502_mem_pkg::*;

   logic [NREQ-1:0]         req_valid;
   logic [NREQ-1:0]         req_ready;
   logic [NREQ*ADDR_W-1:0]  req_addr;
   logic [NREQ-1:0]         req_we;
   logic [NREQ*DATA_W-1:0]  req_wdata;
   logic [NREQ*TAGW-1:0]    req_tag;
   logic [NREQ-1:0]         rsp_valid;
   logic [NREQ*DATA_W-1:0]  rsp_rdata;
   logic [NREQ*TAGW-1:0]    rsp_tag;
   logic [NPORT*ADDR_W-1:0] mem_addr;
   logic [NPORT*DATA_W-1:0] mem_dout;
   logic [NPORT-1:0]        mem_we;
   logic [NPORT*DATA_W-1:0] mem_din;

   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, req_tag, mem_din,
      output req_ready, rsp_valid, rsp_rdata, rsp_tag, mem_addr, mem_dout, mem_we
   );

   modport master (
      output req_valid, req_addr, req_we, req_wdata, req_tag, mem_din,
      input  req_ready, rsp_valid, rsp_rdata, rsp_tag, mem_addr, mem_dout, mem_we
   );
endinterface

// File: rtl/mem_rsp_pipe.sv
// Fixed-latency shift register carrying {valid, requester id, tag} of reads issued on one port.
module mem_rsp_pipe #(
   parameter int LAT  = 1,
   parameter int IDW  = 2,
   parameter int TAGW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [IDW-1:0]  in_id,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   output logic [IDW-1:0]  out_id,
   output logic [TAGW-1:0] out_tag
);
   typedef struct packed {
      logic            valid;
      logic [IDW-1:0]  id;
      logic [TAGW-1:0] tag;
   } entry_t;

   entry_t stage [LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= '{valid: in_valid, id: in_id, tag: in_tag};
         for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign out_valid = stage[LAT-1].valid;
   assign out_id    = stage[LAT-1].id;
   assign out_tag   = stage[LAT-1].tag;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of NREQ requesters onto NPORT memory ports with
// same-cycle address hazard blocking and tagged read-response return.
module mem_port_arbiter
   import ooo6502_mem_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int NPORT    = 2,
   parameter int TAGW     = 4,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
   localparam logic [IDW:0] ONE_W  = (IDW+1)'(1);

   typedef logic [IDW-1:0] id_t;

   addr_t           req_addr_a  [NREQ];
   data_t           req_wdata_a [NREQ];
   logic [TAGW-1:0] req_tag_a   [NREQ];
   data_t           mem_din_a   [NPORT];

   id_t             rr_ptr, rr_next;
   logic [NREQ-1:0] grant;

   logic [NPORT-1:0] port_used, port_we;
   id_t              port_id   [NPORT];
   addr_t            port_addr [NPORT];
   data_t            port_dout [NPORT];

   logic [NPORT-1:0] pipe_valid;
   id_t              pipe_id  [NPORT];
   logic [TAGW-1:0]  pipe_tag [NPORT];

   logic [NREQ-1:0] rsp_v;
   data_t           rsp_d [NREQ];
   logic [TAGW-1:0] rsp_t [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_req
      assign req_addr_a[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
      assign req_wdata_a[i] = bus.req_wdata[i*DATA_W +: DATA_W];
      assign req_tag_a[i]   = bus.req_tag[i*TAGW +: TAGW];
      assign bus.rsp_rdata[i*DATA_W +: DATA_W] = rsp_d[i];
      assign bus.rsp_tag[i*TAGW +: TAGW]       = rsp_t[i];
   end

   // Scan from rr_ptr; a candidate is blocked only by requests already granted this cycle.
   always_comb begin
      logic [IDW:0] idx_w;
      logic [IDW:0] nxt_w;
      id_t          idx;
      logic         hazard;
      int           cnt;
      grant     = '0;
      port_used = '0;
      rr_next   = rr_ptr;
      idx_w     = '0;
      nxt_w     = '0;
      idx       = '0;
      hazard    = 1'b0;
      cnt       = 0;
      for (int p = 0; p < NPORT; p++) port_id[p] = '0;
      for (int off = 0; off < NREQ; off++) begin
         idx_w = {1'b0, rr_ptr} + (IDW+1)'(off);
         if (idx_w >= NREQ_W) idx_w = idx_w - NREQ_W;
         idx    = idx_w[IDW-1:0];
         hazard = 1'b0;
         for (int p = 0; p < NPORT; p++) begin
            if (port_used[p] && (req_addr_a[port_id[p]] == req_addr_a[idx]) &&
                (bus.req_we[port_id[p]] || bus.req_we[idx]))
               hazard = 1'b1;
         end
         if (!rst && bus.req_valid[idx] && (cnt < NPORT) && !hazard) begin
            grant[idx] = 1'b1;
            for (int p = 0; p < NPORT; p++) begin
               if (p == cnt) begin
                  port_used[p] = 1'b1;
                  port_id[p]   = idx;
               end
            end
            cnt++;
            nxt_w   = idx_w + ONE_W;
            rr_next = (nxt_w == NREQ_W) ? '0 : nxt_w[IDW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_ptr <= '0;
      else     rr_ptr <= rr_next;
   end

   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         port_we[p]   = 1'b0;
         port_addr[p] = '0;
         port_dout[p] = '0;
         if (port_used[p]) begin
            port_addr[p] = req_addr_a[port_id[p]];
            port_we[p]   = bus.req_we[port_id[p]];
            if (port_we[p]) port_dout[p] = req_wdata_a[port_id[p]];
         end
      end
   end

   assign bus.req_ready = grant;
   assign bus.mem_we    = port_we;

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      assign bus.mem_addr[p*ADDR_W +: ADDR_W] = port_addr[p];
      assign bus.mem_dout[p*DATA_W +: DATA_W] = port_dout[p];
      assign mem_din_a[p] = bus.mem_din[p*DATA_W +: DATA_W];

      mem_rsp_pipe #(
         .LAT  (READ_LAT),
         .IDW  (IDW),
         .TAGW (TAGW)
      ) u_rsp_pipe (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (port_used[p] & ~port_we[p]),
         .in_id     (port_id[p]),
         .in_tag    (req_tag_a[port_id[p]]),
         .out_valid (pipe_valid[p]),
         .out_id    (pipe_id[p]),
         .out_tag   (pipe_tag[p])
      );
   end

   // Each requester has at most one read in any pipe slot, so ports never collide on an id.
   always_comb begin
      rsp_v = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_d[i] = '0;
         rsp_t[i] = '0;
      end
      for (int p = 0; p < NPORT; p++) begin
         if (pipe_valid[p]) begin
            rsp_v[pipe_id[p]] = 1'b1;
            rsp_d[pipe_id[p]] = mem_din_a[p];
            rsp_t[pipe_id[p]] = pipe_tag[p];
         end
      end
   end

   assign bus.rsp_valid = rsp_v;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates NREQ independent memory requesters (instruction fetch, load unit, store unit, ...) onto NPORT physical memory ports of the out-of-order 6502 core.
- Generalises the current single-port connection: configurable requester count, port count and read latency.
- Round-robin fairness, same-cycle write/address hazard blocking, tagged read responses routed back to the originating requester.
- Sits between the core's memory-issuing units and the external addr/data/we bus pairs.

Parameters:
- NREQ, 3, number of requesters (2..8)
- NPORT, 2, number of memory ports (1..NREQ)
- TAGW, 4, width of the per-request tag returned with read data
- READ_LAT, 1, memory read latency in cycles (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  request granted this cycle (combinational)
- req_addr  in  NREQ*16  flattened addresses, requester i at [16i+15:16i]
- req_we  in  NREQ  1 = write, 0 = read
- req_wdata  in  NREQ*8  flattened write data
- req_tag  in  NREQ*TAGW  flattened tags
- rsp_valid  out  NREQ  read response valid, no backpressure
- rsp_rdata  out  NREQ*8  read data
- rsp_tag  out  NREQ*TAGW  tag of the responding request
- mem_addr  out  NPORT*16  per-port address
- mem_dout  out  NPORT*8  per-port write data
- mem_we  out  NPORT  per-port write enable
- mem_din  in  NPORT*8  per-port read data, valid READ_LAT cycles after address

Behaviour:
- Reset: rr_ptr=0, response pipeline cleared. While rst is high: req_ready=0, mem_we=0, mem_addr=0, mem_dout=0, rsp_valid=0, rsp_rdata=0, rsp_tag=0.
- Arbitration is combinational each cycle. Scan requesters from rr_ptr in increasing index modulo NREQ. Grant the first NPORT eligible valid requesters.
- The k-th grant in scan order drives port k. Unused ports: mem_we=0, mem_addr=0, mem_dout=0.
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both high. A requester must hold addr/we/wdata/tag stable while valid and not ready. req_ready may depend on req_valid.
- Hazard rule: a candidate is ineligible if an earlier-granted request in the same cycle has an equal address and either request is a write. The blocked requester stalls (ready=0) and retries next cycle. Read/read to the same address is allowed.
- rr_ptr update: (index of last grant + 1) mod NREQ. Unchanged if nothing is granted.
- Writes: mem_we=1 in the grant cycle. No response is generated.
- Reads: accepted in cycle T on port k. Pipeline stage entries {valid, requester id, tag} shift each cycle.
  - In cycle T+READ_LAT: rsp_valid[id]=1, rsp_rdata[id]=mem_din[k] (combinational pass-through), rsp_tag[id]=stored tag.
- A requester receives at most one grant per cycle and latency is fixed, so at most one response per requester per cycle. Collision is impossible by construction; the bench asserts it.
- rsp_rdata/rsp_tag for non-responding requesters are 0.
- Reset mid-operation clears in-flight reads. No response is issued for them after reset releases.
- NPORT >= number of valid requesters with no hazards: all are granted the same cycle.

Decomposition:
- Package/header ooo6502_mem_pkg: ADDR_W=16, DATA_W=8, and flattened-slice index macros shared with cpu_ooo.
- One sub-module: mem_rsp_pipe, a per-port READ_LAT-deep shift register of {valid, id, tag}, instantiated NPORT times.
- The arbiter scan stays in the top module.

Test Plan:
1. Reset: assert rst with all req_valid=1 -> req_ready=0, mem_we=0, rsp_valid=0. Release -> first cycle grants req0 on port0 and req1 on port1. rr_ptr becomes 2.
2. Fairness: req0..2 always valid reads, distinct addresses, NPORT=2 -> grant sets {0,1},{2,0},{1,2} repeating. Each requester is granted 2 of every 3 cycles.
3. Read latency: READ_LAT=2, req1 reads 0x1234 tag 5 at T, memory model returns 0xA5 on port0 at T+2 -> rsp_valid[1]=1 at T+2 only, rsp_rdata=0xA5, rsp_tag=5.
4. Hazard: req0 writes 0x0200=0x11, req1 reads 0x0200, same cycle, rr_ptr=0 -> only req0 granted, mem_we[0]=1. req1 granted next cycle and reads 0x11. Read/read to 0x0200 -> both granted.
5. Reset mid-flight: read accepted at T, rst pulsed at T (READ_LAT=1) -> no rsp_valid at T+1 or later.
6. NPORT=1, NREQ=2, writes from both -> alternating grants, at most one mem_we per cycle, no lost writes across 8 requests.
